// File: rtl/jtframe_rq_arbiter.sv
// Round-robin arbiter granting one of three SDRAM request slots to a single-access controller.
// Grant 1 cycle after req; din_ok overlaps the granted slot's we for one cycle; watchdog aborts stuck reads.
module jtframe_rq_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slot0_req,
  input  logic        slot1_req,
  input  logic        slot2_req,
  input  logic        slot0_rnw,
  input  logic        slot1_rnw,
  input  logic        slot2_rnw,
  input  logic [21:0] slot0_addr,
  input  logic [21:0] slot1_addr,
  input  logic [21:0] slot2_addr,
  input  logic [15:0] slot0_wrdata,
  input  logic [15:0] slot1_wrdata,
  input  logic [15:0] slot2_wrdata,
  output logic        slot0_we,
  output logic        slot1_we,
  output logic        slot2_we,
  output logic [31:0] din,
  output logic        din_ok,
  output logic        sdram_req,
  output logic        sdram_rnw,
  output logic [21:0] sdram_addr,
  output logic [15:0] sdram_wrdata,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_dout,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA, DONE} state_t;

  state_t      state_q;
  logic [1:0]  last_q;
  logic [2:0]  we_q;
  logic [7:0]  wdog_q;
  logic [31:0] din_q;
  logic        din_ok_q;
  logic        req_q;
  logic        rnw_q;
  logic [21:0] addr_q;
  logic [15:0] wrdata_q;
  logic        err_q;

  logic [2:0]  req_w;
  logic [2:0]  rnw_w;
  logic [21:0] addr_w [3];
  logic [15:0] wrdata_w [3];
  logic [1:0]  cand1_w, cand2_w, pick_w;
  logic        pick_vld_w;

  assign req_w       = {slot2_req, slot1_req, slot0_req};
  assign rnw_w       = {slot2_rnw, slot1_rnw, slot0_rnw};
  assign addr_w[0]   = slot0_addr;
  assign addr_w[1]   = slot1_addr;
  assign addr_w[2]   = slot2_addr;
  assign wrdata_w[0] = slot0_wrdata;
  assign wrdata_w[1] = slot1_wrdata;
  assign wrdata_w[2] = slot2_wrdata;

  // Search order starts just after the last winner and ends on the last winner itself.
  assign cand1_w = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
  assign cand2_w = (cand1_w == 2'd2) ? 2'd0 : cand1_w + 2'd1;

  always_comb begin
    pick_vld_w = 1'b1;
    pick_w     = last_q;
    if (req_w[cand1_w])      pick_w = cand1_w;
    else if (req_w[cand2_w]) pick_w = cand2_w;
    else if (req_w[last_q])  pick_w = last_q;
    else                     pick_vld_w = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 2'd2;
      we_q     <= 3'b000;
      wdog_q   <= 8'd0;
      din_q    <= 32'd0;
      din_ok_q <= 1'b0;
      req_q    <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= 22'd0;
      wrdata_q <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_w) begin
            req_q    <= 1'b1;
            rnw_q    <= rnw_w[pick_w];
            addr_q   <= addr_w[pick_w];
            wrdata_q <= wrdata_w[pick_w];
            we_q     <= 3'b001 << pick_w;
            last_q   <= pick_w;
            state_q  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_q  <= 1'b0;
            wdog_q <= 8'd0;
            if (sdram_rdy) begin
              din_q    <= sdram_dout;
              din_ok_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          // rdy wins over an expiring watchdog in the same cycle.
          if (sdram_rdy) begin
            din_q    <= sdram_dout;
            din_ok_q <= 1'b1;
            state_q  <= DONE;
          end else if (wdog_q == 8'(TIMEOUT - 1)) begin
            din_q    <= 32'hFFFF_FFFF;
            din_ok_q <= 1'b1;
            err_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        DONE: begin
          din_ok_q <= 1'b0;
          we_q     <= 3'b000;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slot0_we     = we_q[0];
  assign slot1_we     = we_q[1];
  assign slot2_we     = we_q[2];
  assign din          = din_q;
  assign din_ok       = din_ok_q;
  assign sdram_req    = req_q;
  assign sdram_rnw    = rnw_q;
  assign sdram_addr   = addr_q;
  assign sdram_wrdata = wrdata_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_jtframe_rq_arbiter.sv
// Bench for jtframe_rq_arbiter: vector table, hand corner sequences and a transaction-level random model.
module tb_jtframe_rq_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_v;
  logic [2:0]  rnw_v;
  logic [21:0] addr_v [3];
  logic [15:0] wd_v [3];
  logic        s0_we, s1_we, s2_we;
  logic [31:0] din;
  logic        din_ok;
  logic        sdram_req, sdram_rnw;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_wrdata;
  logic        sdram_ack, sdram_rdy;
  logic [31:0] sdram_dout;
  logic        timeout_err;
  logic [2:0]  we_w;

  assign we_w = {s2_we, s1_we, s0_we};

  always #5 clk = ~clk;

  jtframe_rq_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .slot0_req(req_v[0]), .slot1_req(req_v[1]), .slot2_req(req_v[2]),
    .slot0_rnw(rnw_v[0]), .slot1_rnw(rnw_v[1]), .slot2_rnw(rnw_v[2]),
    .slot0_addr(addr_v[0]), .slot1_addr(addr_v[1]), .slot2_addr(addr_v[2]),
    .slot0_wrdata(wd_v[0]), .slot1_wrdata(wd_v[1]), .slot2_wrdata(wd_v[2]),
    .slot0_we(s0_we), .slot1_we(s1_we), .slot2_we(s2_we),
    .din(din), .din_ok(din_ok),
    .sdram_req(sdram_req), .sdram_rnw(sdram_rnw), .sdram_addr(sdram_addr),
    .sdram_wrdata(sdram_wrdata), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .sdram_dout(sdram_dout), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_last;
  bit m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (req[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  typedef struct {
    logic [2:0]  req;
    logic        rnw;
    logic [21:0] addr;
    logic [15:0] wd;
    int          ack_dly;
    int          rdy_dly;
    bit          same;
    logic [31:0] dout;
    int          exp_slot;
    logic [31:0] exp_din;
    bit          exp_err;
  } vec_t;

  // One complete access: request, grant, ack after ack_dly, rdy after rdy_dly (>= TO means never).
  task automatic run_txn(input logic [2:0] req, input int ack_dly, input int rdy_dly,
                         input bit same, input logic [31:0] dout, input int exp_slot,
                         input logic exp_rnw, input logic [21:0] exp_addr,
                         input logic [15:0] exp_wd, input logic [31:0] exp_din,
                         input bit exp_err);
    bit got;
    int lat;
    req_v = req;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (|we_w) begin
        got = 1;
        lat = i;
      end
    end
    req_v = 3'b000;
    if (!got) begin
      chk("grant_wait_expired", 0, 1);
      return;
    end
    chk("grant_latency", lat, 1);
    chk("grant_slot", we_w, 64'd1 << exp_slot);
    chk("sdram_req_set", sdram_req, 1);
    chk("sdram_rnw", sdram_rnw, exp_rnw);
    chk("sdram_addr", sdram_addr, exp_addr);
    chk("sdram_wrdata", sdram_wrdata, exp_wd);
    repeat (ack_dly) begin
      @(negedge clk);
      chk("req_hold", {sdram_req, we_w}, {1'b1, 3'b001 << exp_slot});
    end
    sdram_ack = 1'b1;
    if (same) begin
      sdram_rdy = 1'b1;
      sdram_dout = dout;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    sdram_dout = ~dout;
    chk("req_drop", sdram_req, 0);
    chk("din_ok_after_ack", din_ok, same);
    if (!same) begin
      got = 0;
      lat = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
        if (i - 1 == rdy_dly) begin
          sdram_rdy = 1'b1;
          sdram_dout = dout;
        end else begin
          sdram_rdy = 1'b0;
          sdram_dout = ~dout;
        end
        @(negedge clk);
        if (din_ok) begin
          got = 1;
          lat = i;
        end
      end
      sdram_rdy = 1'b0;
      if (!got) begin
        chk("done_wait_expired", 0, 1);
        return;
      end
      chk("done_latency", lat, (rdy_dly < TO) ? rdy_dly + 1 : TO);
    end
    chk("din", din, exp_din);
    chk("we_with_din_ok", we_w, 64'd1 << exp_slot);
    chk("timeout_err", timeout_err, exp_err);
    @(negedge clk);
    chk("after_done", {din_ok, we_w}, 4'b0000);
    chk("din_held", din, exp_din);
  endtask

  vec_t tbl [12];

  initial begin
    logic [2:0]  rq;
    int          ad, rd, ms, es;
    bit          sm;
    logic [31:0] dv, ed;
    bit          got;

    tbl[0]  = '{3'b010, 1'b1, 22'h01234,  16'h0000, 2, 2, 1'b0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{3'b100, 1'b0, 22'h3FFFFF, 16'hA55A, 0, 1, 1'b0, 32'h12345678, 2, 32'h12345678, 1'b0};
    tbl[2]  = '{3'b111, 1'b1, 22'h00010,  16'h1111, 1, 0, 1'b0, 32'h00000A00, 0, 32'h00000A00, 1'b0};
    tbl[3]  = '{3'b111, 1'b1, 22'h00011,  16'h2222, 1, 0, 1'b0, 32'h00000A01, 1, 32'h00000A01, 1'b0};
    tbl[4]  = '{3'b111, 1'b1, 22'h00012,  16'h3333, 1, 0, 1'b0, 32'h00000A02, 2, 32'h00000A02, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 22'h00013,  16'h4444, 1, 0, 1'b0, 32'h00000A03, 0, 32'h00000A03, 1'b0};
    tbl[6]  = '{3'b111, 1'b1, 22'h00014,  16'h5555, 1, 0, 1'b0, 32'h00000A04, 1, 32'h00000A04, 1'b0};
    tbl[7]  = '{3'b111, 1'b1, 22'h00015,  16'h6666, 1, 0, 1'b0, 32'h00000A05, 2, 32'h00000A05, 1'b0};
    tbl[8]  = '{3'b001, 1'b1, 22'h2AAAA,  16'h7777, 1, 0, 1'b1, 32'h00000001, 0, 32'h00000001, 1'b0};
    tbl[9]  = '{3'b010, 1'b1, 22'h15555,  16'h8888, 0, 99, 1'b0, 32'h0BADF00D, 1, 32'hFFFFFFFF, 1'b1};
    tbl[10] = '{3'b011, 1'b1, 22'h00100,  16'h9999, 0, 3, 1'b0, 32'h55AA55AA, 0, 32'h55AA55AA, 1'b1};
    tbl[11] = '{3'b101, 1'b0, 22'h00200,  16'hBEEF, 3, 2, 1'b0, 32'hCAFE0000, 2, 32'hCAFE0000, 1'b1};

    rst = 1'b1;
    req_v = 3'b000;
    rnw_v = 3'b000;
    for (int s = 0; s < 3; s++) begin
      addr_v[s] = 22'd0;
      wd_v[s] = 16'd0;
    end
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    sdram_dout = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {we_w, din_ok, sdram_req, sdram_rnw, timeout_err}, 7'd0);
    chk("rst_din", din, 0);
    chk("rst_sdram_fields", {sdram_addr, sdram_wrdata}, 38'd0);
    rst = 1'b0;
    @(negedge clk);

    // Controller strobes while idle must be ignored.
    sdram_ack = 1'b1;
    sdram_rdy = 1'b1;
    sdram_dout = 32'h77777777;
    @(negedge clk);
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    chk("idle_strobes_ignored", {we_w, din_ok, sdram_req}, 5'd0);
    chk("idle_din_unchanged", din, 0);

    for (int v = 0; v < 12; v++) begin
      rnw_v = {3{tbl[v].rnw}};
      for (int s = 0; s < 3; s++) begin
        addr_v[s] = tbl[v].addr;
        wd_v[s] = tbl[v].wd;
      end
      run_txn(tbl[v].req, tbl[v].ack_dly, tbl[v].rdy_dly, tbl[v].same, tbl[v].dout,
              tbl[v].exp_slot, tbl[v].rnw, tbl[v].addr, tbl[v].wd, tbl[v].exp_din,
              tbl[v].exp_err);
    end

    // Reset while waiting for data.
    req_v = 3'b001;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = |we_w;
    end
    req_v = 3'b000;
    chk("pre_rst_grant", we_w, 3'b001);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_we_req_ok", {we_w, sdram_req, din_ok}, 5'd0);
    chk("rst_mid_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    m_last = 2;
    m_err = 0;
    rnw_v = 3'b111;
    for (int s = 0; s < 3; s++) begin
      addr_v[s] = 22'h300000 + 22'(s);
      wd_v[s] = 16'hF000 + 16'(s);
    end
    run_txn(3'b111, 1, 1, 1'b0, 32'h600D0000, 0, 1'b1, 22'h300000, 16'hF000, 32'h600D0000, 1'b0);
    m_last = 0;

    for (int t = 0; t < 40; t++) begin
      rq = 3'($urandom_range(1, 7));
      rnw_v = 3'($urandom);
      for (int s = 0; s < 3; s++) begin
        addr_v[s] = 22'($urandom);
        wd_v[s] = 16'($urandom);
      end
      ad = $urandom_range(0, 3);
      ms = $urandom_range(0, 5);
      sm = (ms == 0);
      rd = (ms == 5) ? 9 : $urandom_range(0, TO - 1);
      dv = $urandom;
      es = rr_pick(rq, m_last);
      ed = (sm || rd < TO) ? dv : 32'hFFFFFFFF;
      if (!sm && rd >= TO) m_err = 1;
      run_txn(rq, ad, rd, sm, dv, es, rnw_v[es], addr_v[es], wd_v[es], ed, m_err);
      m_last = es;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
